// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: request/control bundle between the pipeline stages and the stall/flush sequencer.
interface pipeline_ctrl_if;
   logic        rdy;
   logic        if_stall_req;
   logic        id_stall_req;
   logic        mem_stall_req;
   logic        ex_branch_taken;
   logic [31:0] ex_branch_target;
   logic [4:0]  stall;
   logic [4:0]  flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        hang;
   logic [31:0] stall_cycles;
   logic [31:0] flush_count;
   modport master (
      output rdy, if_stall_req, id_stall_req, mem_stall_req, ex_branch_taken, ex_branch_target,
      input  stall, flush, redirect_valid, redirect_pc, hang, stall_cycles, flush_count
   );
   modport slave (
      input  rdy, if_stall_req, id_stall_req, mem_stall_req, ex_branch_taken, ex_branch_target,
      output stall, flush, redirect_valid, redirect_pc, hang, stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the 5-stage pipeline with redirect PC and mem-stall watchdog.
// Define PIPE_CTRL_PERF_EN to build the stall_cycles/flush_count performance counters.
module pipeline_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned MEM_TIMEOUT  = 255
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.slave bus
);
   typedef enum logic {RUN, FLUSH} state_t;
   state_t      state, state_nxt;
   logic [3:0]  fcnt, fcnt_nxt;
   logic        pend, pend_nxt;
   logic [31:0] rpc, rpc_nxt;
   logic [15:0] wd_cnt, wd_inc;
   logic        hang;
   logic [4:0]  stall, flush;
   logic        rv;
   always_comb begin
      state_nxt = state;
      fcnt_nxt  = fcnt;
      pend_nxt  = pend;
      rpc_nxt   = rpc;
      stall     = 5'b00000;
      flush     = 5'b00000;
      rv        = 1'b0;
      if (rst) flush = 5'b11111;
      else if (!bus.rdy) stall = 5'b11111;
      else if (bus.mem_stall_req) begin
         stall = 5'b01111;
         flush = 5'b10000;
      end else if (bus.ex_branch_taken) begin
         flush     = 5'b00110;
         rpc_nxt   = bus.ex_branch_target;
         state_nxt = FLUSH;
         fcnt_nxt  = 4'(FLUSH_CYCLES);
         pend_nxt  = 1'b1;
      end else if (state == FLUSH) begin
         // pend makes the redirect a single pulse even when FLUSH lasts several cycles
         flush     = 5'b00010;
         rv        = pend;
         pend_nxt  = 1'b0;
         fcnt_nxt  = fcnt - 4'd1;
         state_nxt = fcnt <= 4'd1 ? RUN : FLUSH;
      end else if (bus.id_stall_req) begin
         stall = 5'b00011;
         flush = 5'b00100;
      end else if (bus.if_stall_req) begin
         stall = 5'b00001;
         flush = 5'b00010;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= RUN;
         fcnt  <= 4'd0;
         pend  <= 1'b0;
         rpc   <= 32'd0;
      end else if (bus.rdy) begin
         state <= state_nxt;
         fcnt  <= fcnt_nxt;
         pend  <= pend_nxt;
         rpc   <= rpc_nxt;
      end
   end
   assign wd_inc = wd_cnt == 16'hFFFF ? wd_cnt : wd_cnt + 16'd1;
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt <= 16'd0;
         hang   <= 1'b0;
      end else if (bus.rdy) begin
         wd_cnt <= bus.mem_stall_req ? wd_inc : 16'd0;
         hang   <= hang | (bus.mem_stall_req && wd_inc >= 16'(MEM_TIMEOUT));
      end
   end
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cycles, flush_count;
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= 32'd0;
         flush_count  <= 32'd0;
      end else if (bus.rdy) begin
         stall_cycles <= stall_cycles + {31'd0, |stall};
         flush_count  <= flush_count + {31'd0, rv};
      end
   end
   assign bus.stall_cycles = stall_cycles;
   assign bus.flush_count  = flush_count;
`else
   assign bus.stall_cycles = 32'd0;
   assign bus.flush_count  = 32'd0;
`endif
   assign bus.stall          = stall;
   assign bus.flush          = flush;
   assign bus.redirect_valid = rv;
   assign bus.redirect_pc    = rpc;
   assign bus.hang           = hang;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed vectors feed a per-cycle expectation queue; a negedge monitor pops and compares.
module tb_pipeline_ctrl;
   logic clk = 1'b1;
   logic rst;
   pipeline_ctrl_if bus();
   pipeline_ctrl #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(255)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      string       name;
      logic [4:0]  stall;
      logic [4:0]  flush;
      logic        rv;
      logic        crpc;
      logic [31:0] rpc;
      logic        hang;
   } exp_t;
   exp_t q[$];
   int compared = 0;
   int mismatched = 0;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         compared++;
         if (bus.stall !== e.stall || bus.flush !== e.flush || bus.redirect_valid !== e.rv ||
             bus.hang !== e.hang || (e.crpc && bus.redirect_pc !== e.rpc)) begin
            mismatched++;
            $display("FAIL %s: got stall=%b flush=%b rv=%b pc=%h hang=%b, expected stall=%b flush=%b rv=%b pc=%h hang=%b",
                     e.name, bus.stall, bus.flush, bus.redirect_valid, bus.redirect_pc, bus.hang,
                     e.stall, e.flush, e.rv, e.rpc, e.hang);
         end
      end
   end
   task automatic step(input string name, input logic r, input logic rd, input logic ifs, input logic ids,
                       input logic ms, input logic br, input logic [31:0] tgt,
                       input logic [4:0] es, input logic [4:0] ef, input logic erv,
                       input logic crpc, input logic [31:0] erpc, input logic eh);
      exp_t e;
      rst = r;
      bus.rdy = rd;
      bus.if_stall_req = ifs;
      bus.id_stall_req = ids;
      bus.mem_stall_req = ms;
      bus.ex_branch_taken = br;
      bus.ex_branch_target = tgt;
      e.name = name; e.stall = es; e.flush = ef; e.rv = erv; e.crpc = crpc; e.rpc = erpc; e.hang = eh;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask
   task automatic idle(input string name, input logic [4:0] ef, input logic erv, input logic [31:0] erpc, input logic eh);
      step(name, 0, 1, 0, 0, 0, 0, 32'd0, 5'b00000, ef, erv, 1, erpc, eh);
   endtask
   task automatic check32(input string name, input logic [31:0] got, input logic [31:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask
   initial begin
      step("rst0", 1, 1, 0, 0, 0, 0, 32'd0, 5'b00000, 5'b11111, 0, 0, 32'd0, 0);
      step("rst1", 1, 1, 0, 0, 0, 0, 32'd0, 5'b00000, 5'b11111, 0, 0, 32'd0, 0);
      idle("idle_after_rst", 5'b00000, 0, 32'd0, 0);
      step("br_1040", 0, 1, 0, 0, 0, 1, 32'h1040, 5'b00000, 5'b00110, 0, 1, 32'd0, 0);
      idle("br_n1_redirect", 5'b00010, 1, 32'h1040, 0);
      idle("br_n2_flush", 5'b00010, 0, 32'h1040, 0);
      idle("br_n3_run", 5'b00000, 0, 32'h1040, 0);
      step("id_stall", 0, 1, 0, 1, 0, 0, 32'd0, 5'b00011, 5'b00100, 0, 1, 32'h1040, 0);
      idle("id_stall_gone", 5'b00000, 0, 32'h1040, 0);
      step("if_stall", 0, 1, 1, 0, 0, 0, 32'd0, 5'b00001, 5'b00010, 0, 1, 32'h1040, 0);
      step("id_over_if", 0, 1, 1, 1, 0, 0, 32'd0, 5'b00011, 5'b00100, 0, 1, 32'h1040, 0);
      step("br_2000", 0, 1, 0, 0, 0, 1, 32'h2000, 5'b00000, 5'b00110, 0, 1, 32'h1040, 0);
      for (int i = 0; i < 3; i++)
         step("mem_in_flush", 0, 1, 0, 0, 1, 0, 32'd0, 5'b01111, 5'b10000, 0, 1, 32'h2000, 0);
      idle("mem_release_redirect", 5'b00010, 1, 32'h2000, 0);
      idle("mem_release_flush2", 5'b00010, 0, 32'h2000, 0);
      idle("mem_release_run", 5'b00000, 0, 32'h2000, 0);
      step("br_3000", 0, 1, 0, 0, 0, 1, 32'h3000, 5'b00000, 5'b00110, 0, 1, 32'h2000, 0);
      step("rdy_low0", 0, 0, 0, 0, 1, 1, 32'h9999, 5'b11111, 5'b00000, 0, 1, 32'h3000, 0);
      step("rdy_low1", 0, 0, 1, 1, 0, 0, 32'd0, 5'b11111, 5'b00000, 0, 1, 32'h3000, 0);
      idle("rdy_resume_redirect", 5'b00010, 1, 32'h3000, 0);
      step("id_ignored_in_flush", 0, 1, 0, 1, 0, 0, 32'd0, 5'b00000, 5'b00010, 0, 1, 32'h3000, 0);
      idle("rdy_resume_run", 5'b00000, 0, 32'h3000, 0);
      step("br_4000", 0, 1, 0, 0, 0, 1, 32'h4000, 5'b00000, 5'b00110, 0, 1, 32'h3000, 0);
      idle("br4000_redirect", 5'b00010, 1, 32'h4000, 0);
      step("br_5000_in_flush", 0, 1, 0, 0, 0, 1, 32'h5000, 5'b00000, 5'b00110, 0, 1, 32'h4000, 0);
      idle("br5000_redirect", 5'b00010, 1, 32'h5000, 0);
      idle("br5000_flush2", 5'b00010, 0, 32'h5000, 0);
      idle("br5000_run", 5'b00000, 0, 32'h5000, 0);
      step("mem_defers_br", 0, 1, 0, 0, 1, 1, 32'h6000, 5'b01111, 5'b10000, 0, 1, 32'h5000, 0);
      idle("deferred_br_dropped", 5'b00000, 0, 32'h5000, 0);
      for (int i = 0; i < 200; i++)
         step("wd_run200", 0, 1, 0, 0, 1, 0, 32'd0, 5'b01111, 5'b10000, 0, 1, 32'h5000, 0);
      idle("wd_clear", 5'b00000, 0, 32'h5000, 0);
      for (int i = 0; i < 100; i++)
         step("wd_run100", 0, 1, 0, 0, 1, 0, 32'd0, 5'b01111, 5'b10000, 0, 1, 32'h5000, 0);
      idle("wd_no_hang", 5'b00000, 0, 32'h5000, 0);
      for (int i = 0; i < 255; i++)
         step("wd_run255", 0, 1, 0, 0, 1, 0, 32'd0, 5'b01111, 5'b10000, 0, 1, 32'h5000, 0);
      idle("hang_set", 5'b00000, 0, 32'h5000, 1);
      step("hang_rdy_low", 0, 0, 0, 0, 0, 0, 32'd0, 5'b11111, 5'b00000, 0, 1, 32'h5000, 1);
      idle("hang_sticky", 5'b00000, 0, 32'h5000, 1);
`ifdef PIPE_CTRL_PERF_EN
      check32("stall_cycles", bus.stall_cycles, 32'd562);
      check32("flush_count", bus.flush_count, 32'd5);
`else
      check32("stall_cycles_off", bus.stall_cycles, 32'd0);
      check32("flush_count_off", bus.flush_count, 32'd0);
`endif
      step("rst_again", 1, 1, 0, 0, 0, 0, 32'd0, 5'b00000, 5'b11111, 0, 0, 32'd0, 1);
      idle("hang_cleared", 5'b00000, 0, 32'd0, 0);
      check32("perf_reset", bus.stall_cycles | bus.flush_count, 32'd0);
      for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() > 0) begin
         mismatched++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
